// File: rtl/kgp_seg_display_pkg.sv
// Shared definitions for the KGPminiRISC seven-segment output stage:
// digit count, segment codes, converter states and the double-dabble step.
package kgp_seg_display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int CONV_CYCLES = 16;

  // Active-low segment patterns {g,f,e,d,c,b,a} for hex values 0..F
  localparam logic [6:0] SEG_CODES [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } convState_t;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift
  function automatic logic [19:0] dabbleAdjust(input logic [19:0] bcd);
    logic [19:0] adj;
    adj = bcd;
    for (int k = 0; k < 5; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
      end
    end
    return adj;
  endfunction

endpackage

// File: rtl/kgp_seg_display_hex_to_seg7.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_to_seg7
  import kgp_seg_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_CODES[i_nibble];

endmodule

// File: rtl/kgp_seg_display.sv
// Captures the core's 16-bit result and scans it onto a 4-digit multiplexed
// seven-segment display, either as hex or as unsigned decimal produced by a
// sequential double-dabble converter.
module kgp_seg_display
  import kgp_seg_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b0
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           data_in,
  input  logic                  load,
  input  logic                  dec_mode,
  output logic                  busy,
  output logic                  ovf,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] r_refCnt;
  logic [1:0]       r_digIdx;
  logic [15:0]      r_digits;
  logic [15:0]      r_bin;
  logic [19:0]      r_bcd;
  logic [3:0]       r_bitCnt;
  logic             r_ovf;
  logic             r_busy;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;
  convState_t       r_state;
  convState_t       w_nextState;

  logic             w_loadOk;
  logic [19:0]      w_bcdAdj;
  logic [3:0]       w_curNibble;
  logic             w_blank;
  logic [6:0]       w_segRaw;
  logic [6:0]       w_segOut;

  assign w_loadOk = load && (r_state == ST_IDLE);
  assign w_bcdAdj = dabbleAdjust(r_bcd);

  // Refresh counter paces the scan; the digit index steps on every wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_refCnt <= '0;
      r_digIdx <= 2'd0;
    end else if (r_refCnt == CNT_LAST) begin
      r_refCnt <= '0;
      r_digIdx <= r_digIdx + 2'd1;
    end else begin
      r_refCnt <= r_refCnt + 1'b1;
    end
  end

  // Converter state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Converter next-state: a decimal load starts 16 shift cycles then one commit
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:   if (w_loadOk && dec_mode) w_nextState = ST_CONV;
      ST_CONV:   if (r_bitCnt == 4'(CONV_CYCLES - 1)) w_nextState = ST_COMMIT;
      ST_COMMIT: w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  // Capture, double-dabble datapath and displayed-digit register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_digits <= '0;
      r_bin    <= '0;
      r_bcd    <= '0;
      r_bitCnt <= '0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_loadOk) begin
            r_ovf <= 1'b0;
            if (dec_mode) begin
              r_bin    <= data_in;
              r_bcd    <= '0;
              r_bitCnt <= '0;
            end else begin
              r_digits <= data_in;
            end
          end
        end
        ST_CONV: begin
          {r_bcd, r_bin} <= {w_bcdAdj[18:0], r_bin, 1'b0};
          r_bitCnt       <= r_bitCnt + 4'd1;
        end
        ST_COMMIT: begin
          r_digits <= r_bcd[15:0];
          r_ovf    <= (r_bcd[19:16] != 4'd0);
        end
        default: ;
      endcase
    end
  end

  // Select the active digit and decide whether it is a blanked leading zero
  always_comb begin
    w_curNibble = r_digits[3:0];
    w_blank     = 1'b0;
    case (r_digIdx)
      2'd1: begin
        w_curNibble = r_digits[7:4];
        w_blank     = BLANK_LZ && (r_digits[15:4] == 12'd0);
      end
      2'd2: begin
        w_curNibble = r_digits[11:8];
        w_blank     = BLANK_LZ && (r_digits[15:8] == 8'd0);
      end
      2'd3: begin
        w_curNibble = r_digits[15:12];
        w_blank     = BLANK_LZ && (r_digits[15:12] == 4'd0);
      end
      default: ;
    endcase
  end

  hex_to_seg7 u_dec (
    .i_nibble (w_curNibble),
    .o_seg    (w_segRaw)
  );

  assign w_segOut = w_blank ? SEG_BLANK : w_segRaw;

  // Output registers: anode, segments and decimal point move together
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an   <= 4'b1111;
      r_seg  <= SEG_BLANK;
      r_dp   <= 1'b1;
      r_busy <= 1'b0;
    end else begin
      r_an   <= ~(4'b0001 << r_digIdx);
      r_seg  <= w_segOut;
      r_dp   <= ~(r_ovf && (r_digIdx == 2'd3));
      r_busy <= (w_nextState != ST_IDLE);
    end
  end

  assign busy = r_busy;
  assign ovf  = r_ovf;
  assign an   = r_an;
  assign seg  = r_seg;
  assign dp   = r_dp;

endmodule

// File: tb/tb_kgp_seg_display.sv
// Self-checking bench for kgp_seg_display: directed scenarios followed by
// randomized loads and resets, compared every cycle against a value-level model.
module tb_kgp_seg_display;

  localparam int RD = 4;

  logic        clk;
  logic        rst;
  logic [15:0] dataIn;
  logic        load;
  logic        decMode;
  logic        busy, ovf, dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        busyB, ovfB, dpB;
  logic [3:0]  anB;
  logic [6:0]  segB;

  int nCompared;
  int nMismatched;

  // Reference model state
  int   mDigits [4];
  bit   mOvf;
  int   mBusyLeft;
  int   mPend;
  int   mScan;
  logic [3:0] eAn;
  logic [6:0] eSeg, eSegB;
  logic       eDp, eBusy, eOvf;

  logic [6:0] segTbl [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  int pow10 [4] = '{1, 10, 100, 1000};

  kgp_seg_display #(.REFRESH_DIV(RD), .BLANK_LZ(1'b0)) dut (
    .clk(clk), .rst(rst), .data_in(dataIn), .load(load), .dec_mode(decMode),
    .busy(busy), .ovf(ovf), .an(an), .seg(seg), .dp(dp)
  );

  kgp_seg_display #(.REFRESH_DIV(RD), .BLANK_LZ(1'b1)) dutBlank (
    .clk(clk), .rst(rst), .data_in(dataIn), .load(load), .dec_mode(decMode),
    .busy(busyB), .ovf(ovfB), .an(anB), .seg(segB), .dp(dpB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] segFor(input int idx, input bit blankLz);
    bit allZero;
    allZero = 1'b1;
    for (int k = idx; k < 4; k++) begin
      if (mDigits[k] != 0) allZero = 1'b0;
    end
    if (blankLz && idx > 0 && allZero) return 7'h7F;
    return segTbl[mDigits[idx]];
  endfunction

  // One clock edge of the display, described in terms of values and cycle counts
  task automatic modelEdge();
    int idx;
    if (rst) begin
      eAn = 4'b1111; eSeg = 7'h7F; eSegB = 7'h7F; eDp = 1'b1;
      eBusy = 1'b0; eOvf = 1'b0;
      for (int k = 0; k < 4; k++) mDigits[k] = 0;
      mOvf = 1'b0; mBusyLeft = 0; mScan = 0;
    end else begin
      idx   = (mScan / RD) % 4;
      eAn   = ~(4'b0001 << idx);
      eSeg  = segFor(idx, 1'b0);
      eSegB = segFor(idx, 1'b1);
      eDp   = !(mOvf && idx == 3);
      mScan++;
      if (mBusyLeft > 0) begin
        mBusyLeft--;
        if (mBusyLeft == 0) begin
          for (int k = 0; k < 4; k++) mDigits[k] = ((mPend % 10000) / pow10[k]) % 10;
          mOvf = (mPend > 9999);
        end
      end else if (load) begin
        mOvf = 1'b0;
        if (decMode) begin
          mPend = int'(dataIn);
          mBusyLeft = 17;
        end else begin
          for (int k = 0; k < 4; k++) mDigits[k] = (int'(dataIn) >> (4 * k)) & 15;
        end
      end
      eBusy = (mBusyLeft > 0);
      eOvf  = mOvf;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, advance model and DUT, then compare on the falling edge
  task automatic applyStimulus(input logic r, input logic l, input logic d, input logic [15:0] v);
    rst = r; load = l; decMode = d; dataIn = v;
    modelEdge();
    @(posedge clk);
    @(negedge clk);
    checkOutput("an",   32'(an),    32'(eAn));
    checkOutput("seg",  32'(seg),   32'(eSeg));
    checkOutput("segB", 32'(segB),  32'(eSegB));
    checkOutput("dp",   32'(dp),    32'(eDp));
    checkOutput("busy", 32'(busy),  32'(eBusy));
    checkOutput("ovf",  32'(ovf),   32'(eOvf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    int choice;
    logic [15:0] v;
    nCompared = 0;
    nMismatched = 0;
    rst = 1'b1; load = 1'b0; decMode = 1'b0; dataIn = 16'h0000;

    $display("[TB] reset and idle scan");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    idle(20);

    $display("[TB] hex load BEEF");
    applyStimulus(1'b0, 1'b1, 1'b0, 16'hBEEF);
    idle(20);

    $display("[TB] decimal load 1234");
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd1234);
    idle(30);

    $display("[TB] decimal load 65535 (overflow)");
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd65535);
    idle(30);

    $display("[TB] loads while busy are dropped");
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd42);
    idle(3);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'hFFFF);
    idle(3);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'hFFFF);
    idle(30);

    $display("[TB] reset during conversion");
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd1234);
    idle(8);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    idle(20);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 2500; i++) begin
      choice = $urandom_range(0, 4);
      case (choice)
        0:       v = 16'd0;
        1:       v = 16'($urandom_range(0, 99));
        2:       v = 16'($urandom_range(0, 9999));
        3:       v = 16'($urandom_range(10000, 65535));
        default: v = 16'($urandom);
      endcase
      applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 5) == 0),
                    1'($urandom_range(0, 1)), v);
    end
    idle(25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
